mf_job_sched: RTL and testbench

// - Sequences a dot product longer than one mf pass (20 lanes) through the mf MAC datapath.
// - Accepts a job of N 20-lane chunks, gates chunk transfers from the operand source into
//   mf via pushin, and counts returning mf pushout/res results.
// - Accumulates the N partial results into a wide signed sum and reports it with a done pulse.
// - Sits between the operand fetch logic and one mf instance; din/win lanes bypass this block.

---
 rtl/mf_job_sched.sv | 157 +++++++++++++++
 tb/tb_mf_job_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mf_job_sched.sv
// -----------------------------------------------------------------------------
// mf_job_sched
// Sequences a dot product longer than one 20-lane mf pass through a single mf
// MAC instance. A job of N chunks is accepted in IDLE. Chunk transfers from the
// operand source are gated into mf via mf_pushin while in ISSUE. The returning
// mf partial results are summed into a wide signed accumulator through ISSUE
// and DRAIN. A one-cycle done pulse follows the N-th result.
// The din/win operand lanes go straight from the source to mf and do not pass
// through this block.
//
// Optional feature macro: MFS_SAT_EN
//   defined   -> the accumulate saturates, and any clamp sets the sticky sat flag
//   undefined -> the accumulate wraps modulo 2^ACC_W, and sat is tied to 0
//
// Parameters
//   CW     width of the job chunk count (largest job is 2^CW-1 chunks)
//   ACC_W  signed accumulator width (at least 32)
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   job_valid   job request; the requester holds it until job_ready
//   job_nchunk  number of chunks in the job
//   job_ready   high only in IDLE
//   chk_valid   source presents one chunk on the mf lanes
//   chk_ready   high only in ISSUE
//   mf_pushin   chk_valid & chk_ready, in the same cycle as the lane data
//   mf_pushout  mf result strobe
//   mf_res      mf signed 32-bit partial result
//   done        one-cycle pulse; acc_out is final
//   acc_out     signed job sum, held until the next job is accepted
//   busy        high whenever the FSM is not in IDLE
//   err         sticky: a result arrived with none outstanding
//   sat         sticky saturation flag (MFS_SAT_EN only)
// -----------------------------------------------------------------------------
module mf_job_sched #(
  parameter int CW    = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  input  logic [CW-1:0]    job_nchunk,
  output logic             job_ready,
  input  logic             chk_valid,
  output logic             chk_ready,
  output logic             mf_pushin,
  input  logic             mf_pushout,
  input  logic [31:0]      mf_res,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             busy,
  output logic             err,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  n_chunk;
  logic [CW-1:0]  issued;
  logic [CW-1:0]  returned;
  logic           job_take;
  logic           acc_take;
  logic           stray;
  logic [ACC_W-1:0] res_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             clamp;

  assign job_ready = (state == IDLE);
  assign chk_ready = (state == ISSUE);
  assign mf_pushin = chk_valid & chk_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign job_take  = job_ready & job_valid;

  // A result is accepted only while a job is active and at least one chunk is
  // still in flight. The comparison uses the counters before this cycle's
  // updates, so an issue and a return in the same cycle are both counted.
  assign acc_take = mf_pushout && (state == ISSUE || state == DRAIN) && (returned != issued);
  assign stray    = mf_pushout && !acc_take;

  assign res_ext = {{(ACC_W-32){mf_res[31]}}, mf_res};
  assign sum     = acc_out + res_ext;

`ifdef MFS_SAT_EN
  // Signed overflow happens only when both operands have the same sign and the
  // sum's sign differs from it. The clamp goes toward the operands' sign.
  always_comb begin
    clamp   = (acc_out[ACC_W-1] == res_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_out[ACC_W-1]);
    acc_nxt = sum;
    if (clamp)
      acc_nxt = acc_out[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign clamp   = 1'b0;
  assign acc_nxt = sum;
`endif

  // NOTE: sequential state uses non-blocking assignments, so every flop samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: next state is given a default first, so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (job_valid) state_nxt = (job_nchunk != '0) ? ISSUE : DONE;
      ISSUE: if (mf_pushin && issued == n_chunk - 1'b1) state_nxt = DRAIN;
      // The N-th result can arrive only in DRAIN, because one result per chunk
      // returns at least a cycle after that chunk was issued.
      DRAIN: if (acc_take && returned == n_chunk - 1'b1) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_chunk  <= '0;
      issued   <= '0;
      returned <= '0;
      acc_out  <= '0;
      err      <= 1'b0;
    end else if (job_take) begin
      // A new job clears all job-scoped state. A stray strobe in the same cycle is not recorded.
      n_chunk  <= job_nchunk;
      issued   <= '0;
      returned <= '0;
      acc_out  <= '0;
      err      <= 1'b0;
    end else begin
      if (mf_pushin) issued <= issued + 1'b1;
      if (acc_take) begin
        returned <= returned + 1'b1;
        acc_out  <= acc_nxt;
      end
      if (stray) err <= 1'b1;
    end
  end

`ifdef MFS_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (reset)                sat_q <= 1'b0;
    else if (job_take)        sat_q <= 1'b0;
    else if (acc_take && clamp) sat_q <= 1'b1;
  end
  assign sat = sat_q;
`else
  assign sat = 1'b0;
`endif

endmodule

// File: tb/tb_mf_job_sched.sv
// -----------------------------------------------------------------------------
// tb_mf_job_sched
// Directed bench for mf_job_sched. The mf datapath is not instantiated: result
// strobes are driven by hand at the cycle the mf would return them. A second
// scheduler built with ACC_W=33 shares all inputs and is used for the
// accumulator overflow case. Inputs change 1 ns after the rising edge, and
// outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_mf_job_sched;

  localparam int CW     = 8;
  localparam int ACC_W  = 40;
  localparam int MF_LAT = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             job_valid;
  logic [CW-1:0]    job_nchunk;
  logic             job_ready;
  logic             chk_valid;
  logic             chk_ready;
  logic             mf_pushin;
  logic             mf_pushout;
  logic [31:0]      mf_res;
  logic             done;
  logic [ACC_W-1:0] acc_out;
  logic             busy;
  logic             err;
  logic             sat;

  logic             job_ready33, chk_ready33, mf_pushin33, done33, busy33, err33, sat33;
  logic [32:0]      acc_out33;

  int n_checks = 0;
  int n_fail   = 0;
  int pushin_cnt = 0;
  int done_cnt   = 0;
  int p0, d0;
  logic [ACC_W-1:0] exp40;
  logic [32:0]      exp33;
  logic             exp_sat;

  mf_job_sched #(.CW(CW), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_nchunk(job_nchunk),
    .job_ready(job_ready), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .mf_pushin(mf_pushin), .mf_pushout(mf_pushout), .mf_res(mf_res),
    .done(done), .acc_out(acc_out), .busy(busy), .err(err), .sat(sat)
  );

  mf_job_sched #(.CW(CW), .ACC_W(33)) dut33 (
    .clk(clk), .reset(reset), .job_valid(job_valid), .job_nchunk(job_nchunk),
    .job_ready(job_ready33), .chk_valid(chk_valid), .chk_ready(chk_ready33),
    .mf_pushin(mf_pushin33), .mf_pushout(mf_pushout), .mf_res(mf_res),
    .done(done33), .acc_out(acc_out33), .busy(busy33), .err(err33), .sat(sat33)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mf_pushin) pushin_cnt <= pushin_cnt + 1;
    if (done)      done_cnt   <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1; job_valid = 1'b0; job_nchunk = '0;
    chk_valid = 1'b0; mf_pushout = 1'b0; mf_res = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_job_ready", job_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_acc", acc_out, 0);
    check("rst_err", err, 0);
    check("rst_sat", sat, 0);
    check("rst_chk_ready", chk_ready, 0);

    // ---- N=3 back-to-back, results 100,-50,7 at cycles 6..8 ----
    p0 = pushin_cnt; d0 = done_cnt;
    job_valid = 1'b1; job_nchunk = 8'd3;
    tick();                                   // cycle 0 is the first ISSUE cycle
    job_valid = 1'b0;
    check("j1_busy", busy, 1);
    check("j1_chk_ready", chk_ready, 1);
    chk_valid = 1'b1;
    #1 check("j1_pushin_comb", mf_pushin, 1);
    tick(); tick(); tick();                   // transfers in cycles 0,1,2
    chk_valid = 1'b0;
    check("j1_drain_chk_ready", chk_ready, 0);
    check("j1_pushins", pushin_cnt - p0, 3);
    repeat (MF_LAT - 3) tick();               // cycles 3..5
    mf_pushout = 1'b1; mf_res = 32'd100;        tick();
    mf_res = 32'hFFFF_FFCE;                     tick(); // -50
    check("j1_no_early_done", done_cnt - d0, 0);
    mf_res = 32'd7;                             tick();
    mf_pushout = 1'b0;
    check("j1_done_c9", done, 1);
    check("j1_acc", acc_out, 40'd57);
    tick();
    check("j1_done_one_cycle", done_cnt - d0, 1);
    check("j1_idle", job_ready, 1);
    check("j1_acc_held", acc_out, 40'd57);

    // ---- N=2 with a 4-cycle stall between chunks ----
    p0 = pushin_cnt;
    job_valid = 1'b1; job_nchunk = 8'd2;
    tick();
    job_valid = 1'b0;
    check("j2_acc_cleared", acc_out, 0);
    chk_valid = 1'b1; tick();
    chk_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 check("j2_stall_pushin", mf_pushin, 0);
      check("j2_stall_busy", busy, 1);
      tick();
    end
    chk_valid = 1'b1; tick();
    chk_valid = 1'b0;
    check("j2_pushins", pushin_cnt - p0, 2);
    tick();
    check("j2_drain_busy", busy, 1);
    mf_pushout = 1'b1; mf_res = 32'd10; tick();
    check("j2_not_done_yet", done, 0);
    mf_res = 32'hFFFF_FFEC; tick();           // -20
    mf_pushout = 1'b0;
    check("j2_done", done, 1);
    check("j2_busy_in_done", busy, 1);
    check("j2_acc", acc_out, 40'hFF_FFFF_FFF6); // -10
    tick();

    // ---- N=0 ----
    p0 = pushin_cnt;
    job_valid = 1'b1; job_nchunk = 8'd0;
    tick();
    job_valid = 1'b0;
    check("j0_done", done, 1);
    check("j0_acc", acc_out, 0);
    tick();
    check("j0_no_pushin", pushin_cnt - p0, 0);
    check("j0_idle", job_ready, 1);

    // ---- stray pushout in IDLE, then cleared by the next job ----
    mf_pushout = 1'b1; mf_res = 32'd5; tick();
    mf_pushout = 1'b0;
    check("stray_err", err, 1);
    check("stray_acc", acc_out, 0);
    job_valid = 1'b1; job_nchunk = 8'd1; tick();
    job_valid = 1'b0;
    check("stray_err_cleared", err, 0);
    chk_valid = 1'b1; tick();
    chk_valid = 1'b0;
    mf_pushout = 1'b1; mf_res = 32'd9; tick();
    mf_pushout = 1'b0;
    check("after_stray_done", done, 1);
    check("after_stray_acc", acc_out, 40'd9);
    check("after_stray_err", err, 0);
    tick();

    // ---- three results of 0x7FFFFFFF (ACC_W=33 overflow) ----
    job_valid = 1'b1; job_nchunk = 8'd3; tick();
    job_valid = 1'b0;
    chk_valid = 1'b1; tick(); tick(); tick();
    chk_valid = 1'b0;
    mf_pushout = 1'b1; mf_res = 32'h7FFF_FFFF; tick(); tick(); tick();
    mf_pushout = 1'b0;
    exp40 = ACC_W'(3 * 64'h7FFF_FFFF);
`ifdef MFS_SAT_EN
    exp33 = 33'h0_FFFF_FFFF;
    exp_sat = 1'b1;
`else
    exp33 = 33'(3 * 64'h7FFF_FFFF);
    exp_sat = 1'b0;
`endif
    check("ovf_done33", done33, 1);
    check("ovf_acc33", acc_out33, exp33);
    check("ovf_sat33", sat33, exp_sat);
    check("ovf_acc40", acc_out, exp40);
    check("ovf_sat40", sat, 0);
    tick();

    // ---- reset during DRAIN of an N=4 job ----
    job_valid = 1'b1; job_nchunk = 8'd4; tick();
    job_valid = 1'b0;
    chk_valid = 1'b1; repeat (4) tick();
    chk_valid = 1'b0;
    mf_pushout = 1'b1; mf_res = 32'd11; tick(); tick();
    mf_pushout = 1'b0;
    check("mid_drain_busy", busy, 1);
    check("mid_drain_acc", acc_out, 40'd22);
    reset = 1'b1; tick();
    reset = 1'b0;
    check("abort_idle", job_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_acc", acc_out, 0);
    check("abort_err", err, 0);
    check("abort_sat", sat, 0);
    d0 = done_cnt;
    job_valid = 1'b1; job_nchunk = 8'd1; tick();
    job_valid = 1'b0;
    chk_valid = 1'b1; tick();
    chk_valid = 1'b0;
    tick();
    mf_pushout = 1'b1; mf_res = 32'hFFFF_FFFD; tick(); // -3
    mf_pushout = 1'b0;
    check("post_abort_done", done, 1);
    check("post_abort_acc", acc_out, 40'hFF_FFFF_FFFD);
    tick();
    check("post_abort_idle", job_ready, 1);
    check("post_abort_done_cnt", done_cnt - d0, 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
